evg_dbus_generator: RTL and testbench

Parametrised distributed-bus generator for the event generator transmit path. It drives bit 0 with a registered heartbeat and bit 1 with a fixed-interval ping. Above those it drives CHANNEL_COUNT programmable, runtime-configurable pulse-train channels. It sits in the evgTxClk domain and feeds the evgDistributedBus input of the event source.

---
 rtl/evg_dbus_pkg.sv | 19 +
 rtl/evg_dbus_channel.sv | 139 +++++++++++++
 rtl/evg_dbus_generator.sv | 104 ++++++++++
 tb/tb_evg_dbus_generator.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/evg_dbus_pkg.sv
// evg_dbus_pkg
//   Shared definitions for the event-generator distributed-bus generator.
//   - chanStateT: per-channel state (IDLE, ARMED, RUN). ARMED is only
//     reachable when EVG_DBUS_RESYNC_EN is defined.
//   - Fixed bit positions on the distributed bus. Bit 0 is the heartbeat,
//     bit 1 is the ping, and the programmable channels start at bit 2.
package evg_dbus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2
  } chanStateT;

  localparam int HEARTBEAT_BIT     = 0;
  localparam int PING_BIT          = 1;
  localparam int FIRST_CHANNEL_BIT = 2;

endpackage

// File: rtl/evg_dbus_channel.sv
// evg_dbus_channel
//   One programmable pulse-train channel. It holds the shadow period/high
//   registers, the active copies used by the running counter, and the
//   IDLE/ARMED/RUN state machine.
//   Optional feature: EVG_DBUS_RESYNC_EN. When it is defined, an enabled
//   channel waits in ARMED for a heartbeat, and every heartbeat restarts the
//   counter at 0.
// Ports:
//   evgTxClk   in   clock, rising edge
//   evgReset   in   synchronous active-high reset
//   cfgWrite   in   decoded one-cycle write aimed at this channel
//   cfgPeriod  in   period in cycles (values < 2 disable the channel)
//   cfgHigh    in   high cycles per period
//   cfgEnable  in   enable written together with period/high
//   heartbeat  in   heartbeat request (only used for resync)
//   chanBit    out  combinational channel bit for the current cycle; the top
//                   registers it onto the bus
//   running    out  high while the channel is in RUN (comes straight from a flop)
module evg_dbus_channel
  import evg_dbus_pkg::*;
#(
  parameter int PERIOD_WIDTH = 24
) (
  input  logic                    evgTxClk,
  input  logic                    evgReset,
  input  logic                    cfgWrite,
  input  logic [PERIOD_WIDTH-1:0] cfgPeriod,
  input  logic [PERIOD_WIDTH-1:0] cfgHigh,
  input  logic                    cfgEnable,
  input  logic                    heartbeat,
  output logic                    chanBit,
  output logic                    running
);

`ifdef EVG_DBUS_RESYNC_EN
  localparam chanStateT ENABLE_STATE = ARMED;
`else
  localparam chanStateT ENABLE_STATE = RUN;
`endif

  chanStateT               stateReg, stateNext;
  logic [PERIOD_WIDTH-1:0] countReg, countNext;
  logic [PERIOD_WIDTH-1:0] shadowPeriodReg, shadowHighReg;
  logic [PERIOD_WIDTH-1:0] activePeriodReg, activePeriodNext;
  logic [PERIOD_WIDTH-1:0] activeHighReg, activeHighNext;
  logic [PERIOD_WIDTH-1:0] countEff;
  logic                    cfgValid, cfgKill, atWrap, resyncHit;

  // A heartbeat makes the current cycle the C=0 cycle, so the bit registered
  // this edge lines up with the heartbeat bit on bus[0].
`ifdef EVG_DBUS_RESYNC_EN
  assign resyncHit = heartbeat && ((stateReg == RUN) || (stateReg == ARMED));
`else
  logic unusedHeartbeat;
  assign unusedHeartbeat = heartbeat;
  assign resyncHit       = 1'b0;
`endif

  assign running = (stateReg == RUN);

  always_comb begin
    cfgValid         = cfgWrite && cfgEnable && (cfgPeriod >= PERIOD_WIDTH'(2));
    cfgKill          = cfgWrite && !cfgValid;
    countEff         = resyncHit ? '0 : countReg;
    atWrap           = (stateReg == RUN) &&
                       (countReg == activePeriodReg - PERIOD_WIDTH'(1));
    // A disabling write silences the bit already on the edge that takes it.
    chanBit          = !cfgKill && ((stateReg == RUN) || resyncHit) &&
                       (countEff < activeHighReg);
    stateNext        = stateReg;
    countNext        = countReg;
    activePeriodNext = activePeriodReg;
    activeHighNext   = activeHighReg;

    if (cfgKill) begin
      stateNext = IDLE;
      countNext = '0;
    end else begin
      case (stateReg)
        IDLE: begin
          if (cfgValid) begin
            stateNext        = ENABLE_STATE;
            countNext        = '0;
            activePeriodNext = cfgPeriod;
            activeHighNext   = cfgHigh;
          end
        end
        ARMED: begin
          // Nothing is being emitted yet, so new values can be taken directly.
          if (cfgValid) begin
            activePeriodNext = cfgPeriod;
            activeHighNext   = cfgHigh;
          end
          if (resyncHit) begin
            stateNext = RUN;
            countNext = PERIOD_WIDTH'(1);
          end
        end
        RUN: begin
          // Pending values are taken only at a period boundary, so no runt
          // pulse is produced. A write that lands on that same edge is still
          // in flight and waits for the next wrap.
          if (atWrap) begin
            activePeriodNext = shadowPeriodReg;
            activeHighNext   = shadowHighReg;
          end
          if (resyncHit)   countNext = PERIOD_WIDTH'(1);
          else if (atWrap) countNext = '0;
          else             countNext = countReg + PERIOD_WIDTH'(1);
        end
        default: begin
          stateNext = IDLE;
          countNext = '0;
        end
      endcase
    end
  end

  always_ff @(posedge evgTxClk) begin
    if (evgReset) begin
      stateReg        <= IDLE;
      countReg        <= '0;
      shadowPeriodReg <= '0;
      shadowHighReg   <= '0;
      activePeriodReg <= '0;
      activeHighReg   <= '0;
    end else begin
      stateReg        <= stateNext;
      countReg        <= countNext;
      activePeriodReg <= activePeriodNext;
      activeHighReg   <= activeHighNext;
      if (cfgWrite) begin
        shadowPeriodReg <= cfgPeriod;
        shadowHighReg   <= cfgHigh;
      end
    end
  end

endmodule

// File: rtl/evg_dbus_generator.sv
// evg_dbus_generator
//   Distributed-bus generator for the event generator transmit path.
//   bus[0] is the registered heartbeat request. bus[1] is a one-cycle ping
//   every PING_INTERVAL cycles. Bits 2..CHANNEL_COUNT+1 carry the
//   programmable channels, and all bits above them are 0.
//   Optional feature: EVG_DBUS_RESYNC_EN (heartbeat-aligned channel start and
//   restart; see evg_dbus_channel).
// Ports:
//   evgTxClk             in   sole clock, rising edge
//   evgReset             in   synchronous active-high reset
//   evgHeartbeatRequest  in   heartbeat request
//   evgCfgStrobe         in   one-cycle configuration write
//   evgCfgChannel        in   target channel (>= CHANNEL_COUNT is ignored)
//   evgCfgPeriod         in   period in cycles
//   evgCfgHigh           in   high cycles per period
//   evgCfgEnable         in   channel enable
//   evgDistributedBus    out  registered distributed bus
//   evgChannelRunning    out  per-channel RUN indicator
module evg_dbus_generator
  import evg_dbus_pkg::*;
#(
  parameter int TXCLK_NOMINAL_FREQUENCY = 125000000,
  parameter int DISTRIBUTED_BUS_WIDTH   = 8,
  parameter int CHANNEL_COUNT           = 4,
  parameter int PERIOD_WIDTH            = 24,
  parameter int PING_INTERVAL           = 625,
  parameter int CHAN_SEL_WIDTH          = (CHANNEL_COUNT > 1) ? $clog2(CHANNEL_COUNT) : 1
) (
  input  logic                             evgTxClk,
  input  logic                             evgReset,
  input  logic                             evgHeartbeatRequest,
  input  logic                             evgCfgStrobe,
  input  logic [CHAN_SEL_WIDTH-1:0]        evgCfgChannel,
  input  logic [PERIOD_WIDTH-1:0]          evgCfgPeriod,
  input  logic [PERIOD_WIDTH-1:0]          evgCfgHigh,
  input  logic                             evgCfgEnable,
  output logic [DISTRIBUTED_BUS_WIDTH-1:0] evgDistributedBus,
  output logic [CHANNEL_COUNT-1:0]         evgChannelRunning
);

  localparam int PING_CW = (PING_INTERVAL > 2) ? $clog2(PING_INTERVAL) : 1;
  localparam logic [PING_CW-1:0] PING_RELOAD = PING_CW'(PING_INTERVAL - 1);

  if (TXCLK_NOMINAL_FREQUENCY <= 0) begin : gBadFreq
    $error("evg_dbus_generator: TXCLK_NOMINAL_FREQUENCY must be positive");
  end
  if (DISTRIBUTED_BUS_WIDTH < CHANNEL_COUNT + 2) begin : gBadWidth
    $error("evg_dbus_generator: bus too narrow for CHANNEL_COUNT");
  end
  if (PING_INTERVAL < 2) begin : gBadPing
    $error("evg_dbus_generator: PING_INTERVAL must be at least 2");
  end
  if (CHAN_SEL_WIDTH < $clog2(CHANNEL_COUNT)) begin : gBadSel
    $error("evg_dbus_generator: CHAN_SEL_WIDTH cannot address every channel");
  end

  logic [PING_CW-1:0]               pingCountReg;
  logic [DISTRIBUTED_BUS_WIDTH-1:0] busReg, busNext;
  logic [CHANNEL_COUNT-1:0]         chanBits, chanRunning, chanWrite;

  for (genvar gi = 0; gi < CHANNEL_COUNT; gi++) begin : gChan
    // A write that arrives together with reset is dropped here as well as by
    // the channel's own reset.
    assign chanWrite[gi] = evgCfgStrobe && !evgReset &&
                           (32'(evgCfgChannel) == gi);

    evg_dbus_channel #(
      .PERIOD_WIDTH (PERIOD_WIDTH)
    ) uChan (
      .evgTxClk  (evgTxClk),
      .evgReset  (evgReset),
      .cfgWrite  (chanWrite[gi]),
      .cfgPeriod (evgCfgPeriod),
      .cfgHigh   (evgCfgHigh),
      .cfgEnable (evgCfgEnable),
      .heartbeat (evgHeartbeatRequest),
      .chanBit   (chanBits[gi]),
      .running   (chanRunning[gi])
    );
  end

  always_comb begin
    busNext                                         = '0;
    busNext[HEARTBEAT_BIT]                          = evgHeartbeatRequest;
    busNext[PING_BIT]                               = (pingCountReg == '0);
    busNext[FIRST_CHANNEL_BIT +: CHANNEL_COUNT]     = chanBits;
  end

  // The ping counter starts at PING_INTERVAL-1, so the first registered ping
  // appears exactly PING_INTERVAL cycles after reset is released.
  always_ff @(posedge evgTxClk) begin
    if (evgReset) begin
      busReg       <= '0;
      pingCountReg <= PING_RELOAD;
    end else begin
      busReg       <= busNext;
      pingCountReg <= (pingCountReg == '0) ? PING_RELOAD : pingCountReg - 1'b1;
    end
  end

  assign evgDistributedBus = busReg;
  assign evgChannelRunning = chanRunning;

endmodule

// File: tb/tb_evg_dbus_generator.sv
// tb_evg_dbus_generator
//   Self-checking bench for evg_dbus_generator. A cycle-level behavioural
//   model is built from the bus rules (phase arithmetic per channel, ping as
//   "cycles since reset is a multiple of the interval"). It is compared
//   against the DUT after every clock edge. Directed constant checks cover
//   the documented scenarios, and a randomized section follows them.
//   Works with or without EVG_DBUS_RESYNC_EN.
module tb_evg_dbus_generator;

  localparam int BW   = 8;
  localparam int CH   = 4;
  localparam int PW   = 24;
  localparam int PING = 625;
  localparam int SELW = 3;   // wide enough to present out-of-range channel 5
`ifdef EVG_DBUS_RESYNC_EN
  localparam bit RESYNC = 1'b1;
`else
  localparam bit RESYNC = 1'b0;
`endif

  logic            evgTxClk = 1'b0;
  logic            evgReset;
  logic            evgHeartbeatRequest;
  logic            evgCfgStrobe;
  logic [SELW-1:0] evgCfgChannel;
  logic [PW-1:0]   evgCfgPeriod;
  logic [PW-1:0]   evgCfgHigh;
  logic            evgCfgEnable;
  logic [BW-1:0]   evgDistributedBus;
  logic [CH-1:0]   evgChannelRunning;

  always #5 evgTxClk = ~evgTxClk;

  evg_dbus_generator #(
    .TXCLK_NOMINAL_FREQUENCY (125000000),
    .DISTRIBUTED_BUS_WIDTH   (BW),
    .CHANNEL_COUNT           (CH),
    .PERIOD_WIDTH            (PW),
    .PING_INTERVAL           (PING),
    .CHAN_SEL_WIDTH          (SELW)
  ) dut (
    .evgTxClk            (evgTxClk),
    .evgReset            (evgReset),
    .evgHeartbeatRequest (evgHeartbeatRequest),
    .evgCfgStrobe        (evgCfgStrobe),
    .evgCfgChannel       (evgCfgChannel),
    .evgCfgPeriod        (evgCfgPeriod),
    .evgCfgHigh          (evgCfgHigh),
    .evgCfgEnable        (evgCfgEnable),
    .evgDistributedBus   (evgDistributedBus),
    .evgChannelRunning   (evgChannelRunning)
  );

  int testsRun    = 0;
  int testsFailed = 0;

  // Reference model state. Per channel: whether it runs or waits for a
  // heartbeat, its phase within the period, and active/pending period+high.
  bit            mRun  [CH];
  bit            mArm  [CH];
  int            mPhase[CH];
  int            mPer  [CH];
  int            mHigh [CH];
  int            pPer  [CH];
  int            pHigh [CH];
  int            sinceRst;
  logic [BW-1:0] expBus;
  logic [CH-1:0] expRun;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] want);
    testsRun++;
    if (got !== want) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, want, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic modelEdge();
    logic [BW-1:0] nb;
    if (evgReset) begin
      sinceRst = 0;
      expBus   = '0;
      expRun   = '0;
      for (int i = 0; i < CH; i++) begin
        mRun[i] = 1'b0; mArm[i] = 1'b0; mPhase[i] = 0;
        mPer[i] = 0; mHigh[i] = 0; pPer[i] = 0; pHigh[i] = 0;
      end
      return;
    end
    sinceRst++;
    nb    = '0;
    nb[0] = evgHeartbeatRequest;
    nb[1] = ((sinceRst % PING) == 0);
    for (int i = 0; i < CH; i++) begin
      bit wr, ok, hit, edgeWrap;
      int ph, nP, nH;
      wr  = evgCfgStrobe && (int'(evgCfgChannel) == i);
      nP  = int'(evgCfgPeriod);
      nH  = int'(evgCfgHigh);
      ok  = wr && evgCfgEnable && (nP >= 2);
      hit = RESYNC && evgHeartbeatRequest && (mRun[i] || mArm[i]);
      ph  = hit ? 0 : mPhase[i];
      nb[2+i] = !(wr && !ok) && (mRun[i] || hit) && (ph < mHigh[i]);
      if (wr && !ok) begin
        mRun[i] = 1'b0; mArm[i] = 1'b0; mPhase[i] = 0;
      end else if (ok && !mRun[i] && !mArm[i]) begin
        mRun[i] = !RESYNC; mArm[i] = RESYNC; mPhase[i] = 0;
        mPer[i] = nP; mHigh[i] = nH; pPer[i] = nP; pHigh[i] = nH;
      end else begin
        edgeWrap = mRun[i] && (mPhase[i] == mPer[i] - 1);
        if (ok && mArm[i]) begin mPer[i] = nP; mHigh[i] = nH; end
        if (edgeWrap) begin mPer[i] = pPer[i]; mHigh[i] = pHigh[i]; end
        if (mRun[i] || hit) begin
          mPhase[i] = hit ? 1 : (edgeWrap ? 0 : ph + 1);
          mRun[i]   = 1'b1;
          mArm[i]   = 1'b0;
        end
        if (ok) begin pPer[i] = nP; pHigh[i] = nH; end
      end
      expRun[i] = mRun[i];
    end
    expBus = nb;
  endtask

  task automatic cycle(input string tag);
    @(posedge evgTxClk);
    modelEdge();
    #1;
    checkVal({tag, ".bus"}, 32'(evgDistributedBus), 32'(expBus));
    checkVal({tag, ".run"}, 32'(evgChannelRunning), 32'(expRun));
  endtask

  task automatic writeCfg(input int ch, input int per, input int high, input bit en);
    evgCfgStrobe  = 1'b1;
    evgCfgChannel = SELW'(ch);
    evgCfgPeriod  = PW'(per);
    evgCfgHigh    = PW'(high);
    evgCfgEnable  = en;
    $display("[TB] cfg write ch=%0d P=%0d H=%0d E=%0d rst=%0d", ch, per, high, en, evgReset);
    cycle("cfg");
    evgCfgStrobe = 1'b0;
  endtask

  initial begin
    evgReset = 1'b1; evgHeartbeatRequest = 1'b0; evgCfgStrobe = 1'b0;
    evgCfgChannel = '0; evgCfgPeriod = '0; evgCfgHigh = '0; evgCfgEnable = 1'b0;

    // Reset state
    repeat (3) cycle("reset");
    checkVal("resetBus", 32'(evgDistributedBus), 32'h0);
    checkVal("resetRun", 32'(evgChannelRunning), 32'h0);
    evgReset = 1'b0;

    // Idle window: ping cadence and heartbeat pass-through
    for (int n = 1; n <= 2000; n++) begin
      evgHeartbeatRequest = (n == 101) || (n >= 201 && n <= 203);
      cycle("idle");
      if (n == 101 || n == 201 || n == 203) checkVal("hbHigh", 32'(evgDistributedBus[0]), 32'h1);
      if (n == 102 || n == 204)             checkVal("hbLow", 32'(evgDistributedBus[0]), 32'h0);
      if (n == 625 || n == 1250 || n == 1875) checkVal("ping", 32'(evgDistributedBus[1]), 32'h1);
      if (n == 624 || n == 626)             checkVal("pingGap", 32'(evgDistributedBus[1]), 32'h0);
    end
    evgHeartbeatRequest = 1'b0;
    $display("[TB] idle window done, %0d checks so far", testsRun);

`ifndef EVG_DBUS_RESYNC_EN
    // Channel 0 start, runt-free reprogram, then disable
    writeCfg(0, 10, 3, 1'b1);
    checkVal("ch0RunT1", 32'(evgChannelRunning[0]), 32'h1);
    for (int k = 0; k < 10; k++) begin
      cycle("ch0");
      checkVal("ch0Pattern", 32'(evgDistributedBus[2]), (k < 3) ? 32'h1 : 32'h0);
    end
    repeat (3) cycle("ch0");
    writeCfg(0, 4, 4, 1'b1);
    checkVal("ch0OldTail", 32'(evgDistributedBus[2]), 32'h0);
    for (int k = 1; k <= 12; k++) begin
      cycle("ch0new");
      checkVal("ch0NewPattern", 32'(evgDistributedBus[2]), (k >= 7) ? 32'h1 : 32'h0);
    end
    writeCfg(0, 4, 4, 1'b0);
    checkVal("ch0OffBit", 32'(evgDistributedBus[2]), 32'h0);
    checkVal("ch0OffRun", 32'(evgChannelRunning[0]), 32'h0);
`endif

    // Out-of-range channel write must not disturb channel 1
    writeCfg(1, 5, 2, 1'b1);
    repeat (4) cycle("ch1");
    writeCfg(5, 0, 0, 1'b0);
    checkVal("oorRun", 32'(evgChannelRunning), RESYNC ? 32'h0 : 32'h2);
    repeat (6) cycle("oor");

    // Strobe together with reset is ignored
    evgReset = 1'b1;
    writeCfg(0, 5, 2, 1'b1);
    checkVal("rstStrobeBus", 32'(evgDistributedBus), 32'h0);
    evgReset = 1'b0;
    repeat (4) cycle("postRst");
    checkVal("rstStrobeRun", 32'(evgChannelRunning), 32'h0);

`ifdef EVG_DBUS_RESYNC_EN
    // Armed channel waits for heartbeat; heartbeat realigns mid-period
    writeCfg(1, 8, 1, 1'b1);
    for (int k = 0; k < 5; k++) begin
      cycle("armed");
      checkVal("armedQuiet", 32'(evgDistributedBus[3]), 32'h0);
    end
    checkVal("armedRun", 32'(evgChannelRunning[1]), 32'h0);
    for (int r = 0; r < 2; r++) begin
      evgHeartbeatRequest = 1'b1;
      cycle("sync");
      evgHeartbeatRequest = 1'b0;
      checkVal("syncHb", 32'(evgDistributedBus[0]), 32'h1);
      checkVal("syncCh", 32'(evgDistributedBus[3]), 32'h1);
      for (int k = 1; k <= 8; k++) begin
        cycle("syncRep");
        checkVal("syncRepeat", 32'(evgDistributedBus[3]), (k == 8) ? 32'h1 : 32'h0);
      end
      repeat (3) cycle("midPeriod");
    end
`endif

    // Randomized traffic against the model
    evgReset = 1'b1;
    cycle("randRst");
    evgReset = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      evgReset            = ($urandom_range(0, 599) == 0);
      evgHeartbeatRequest = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 7) == 0) begin
        evgCfgStrobe  = 1'b1;
        evgCfgChannel = SELW'($urandom_range(0, 5));
        evgCfgPeriod  = PW'($urandom_range(0, 12));
        evgCfgHigh    = PW'($urandom_range(0, 14));
        evgCfgEnable  = ($urandom_range(0, 3) != 0);
        $display("[TB] cfg write ch=%0d P=%0d H=%0d E=%0d rst=%0d", evgCfgChannel,
                 evgCfgPeriod, evgCfgHigh, evgCfgEnable, evgReset);
      end else begin
        evgCfgStrobe = 1'b0;
      end
      cycle("rand");
    end
    evgCfgStrobe = 1'b0; evgReset = 1'b0; evgHeartbeatRequest = 1'b0;

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
